// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder:
// MMIO offsets, STATUS layout, region decode.
package dm_pkg;

  localparam logic [1:0] OFS_CYCLE  = 2'd0;
  localparam logic [1:0] OFS_TOHOST = 2'd1;
  localparam logic [1:0] OFS_TXDATA = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_COUNT_LO = 2;
  localparam int ST_COUNT_HI = 4;
  localparam int ST_OVERFLOW = 5;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  function automatic logic [63:0] mask_merge(
    input logic [63:0] old,
    input logic [63:0] wdata,
    input logic [63:0] we
  );
    return (old & ~we) | (wdata & we);
  endfunction

endpackage

// File: rtl/dm_console_fifo.sv
// Console TX byte FIFO: registered push, valid/ready drain,
// sticky overflow when a push finds it full with no pop.
module dm_console_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          ready,
  output logic          valid,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [7:0]    store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign valid   = ~empty;
  assign rdata   = store[rd_ptr];
  assign pop     = valid & ready;
  // a pop on the same edge frees the slot a full push needs
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~pop) count <= count + 1'b1;
      else if (~do_push & pop) count <= count - 1'b1;
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: 64-bit RAM plus MMIO window
// (cycle counter, tohost/halt, console TX FIFO).
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_0001_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = "dm.hex"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_dm_addr,
  input  logic        i_dm_cs,
  input  logic [63:0] i_dm_we,
  input  logic [63:0] i_dm_data,
  output logic [63:0] o_dm_data,
  output logic        o_err,
  output logic        o_halt,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [63:0]   mem [DEPTH];
  region_e       region;
  logic [63:0]   ofs_full;
  logic [1:0]    ofs;
  logic [AW-1:0] idx;
  logic          wr;
  logic          rd;
  logic          mmio_wr;
  logic          tx_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic [63:0]   cycle_q;
  logic [63:0]   cycle_nxt;
  logic [63:0]   tohost_q;
  logic [63:0]   tohost_nxt;
  logic [63:0]   status;
  logic [63:0]   rdata_nxt;

  assign ofs_full = i_dm_addr - MMIO_BASE;
  assign ofs      = ofs_full[1:0];
  assign idx      = i_dm_addr[AW-1:0];

  always_comb begin
    region = REG_NONE;
    if (i_dm_addr < 64'(DEPTH)) region = REG_RAM;
    else if (i_dm_addr >= MMIO_BASE && ofs_full < 64'd4) region = REG_MMIO;
  end

  assign wr         = i_dm_cs & (|i_dm_we);
  assign rd         = i_dm_cs & ~(|i_dm_we);
  assign mmio_wr    = wr & (region == REG_MMIO);
  assign tx_push    = mmio_wr & (ofs == OFS_TXDATA) & (|i_dm_we[7:0]);
  assign cycle_nxt  = cycle_q + 64'd1;
  assign tohost_nxt = mask_merge(tohost_q, i_dm_data, i_dm_we);

  always_comb begin
    status = '0;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_FULL]                 = fifo_full;
    status[ST_COUNT_HI:ST_COUNT_LO] = 3'(fifo_count);
    status[ST_OVERFLOW]             = fifo_ovf;
  end

  always_comb begin
    rdata_nxt = '0;
    unique case (region)
      REG_RAM:  rdata_nxt = mem[idx];
      REG_MMIO: begin
        unique case (ofs)
          OFS_CYCLE:  rdata_nxt = cycle_q;
          OFS_TOHOST: rdata_nxt = tohost_q;
          OFS_STATUS: rdata_nxt = status;
          default:    rdata_nxt = '0;
        endcase
      end
      default:  rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr && region == REG_RAM)
      mem[idx] <= mask_merge(mem[idx], i_dm_data, i_dm_we);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_dm_data <= '0;
      o_err     <= 1'b0;
      o_halt    <= 1'b0;
      tohost_q  <= '0;
      cycle_q   <= '0;
    end else begin
      cycle_q <= cycle_nxt;
      o_err   <= i_dm_cs && (region == REG_NONE);
      if (rd) o_dm_data <= rdata_nxt;
      if (mmio_wr && ofs == OFS_TOHOST) begin
        tohost_q <= tohost_nxt;
        if (tohost_nxt[0]) o_halt <= 1'b1;
      end
    end
  end

  dm_console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (tx_push),
    .wdata   (i_dm_data[7:0]),
    .ready   (i_tx_ready),
    .valid   (o_tx_valid),
    .rdata   (o_tx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .overflow(fifo_ovf)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table,
// read/err scoreboard, TX byte scoreboard, corner sequences.
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] MB    = 64'h0000_0000_0001_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] i_dm_addr = '0;
  logic        i_dm_cs = 1'b0;
  logic [63:0] i_dm_we = '0;
  logic [63:0] i_dm_data = '0;
  logic [63:0] o_dm_data;
  logic        o_err;
  logic        o_halt;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready = 1'b0;

  always #5 i_clk = ~i_clk;

  data_mem_responder #(
    .DEPTH(DEPTH),
    .MMIO_BASE(MB),
    .FIFO_DEPTH(4),
    .INIT_FILE("")
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_dm_addr(i_dm_addr),
    .i_dm_cs(i_dm_cs),
    .i_dm_we(i_dm_we),
    .i_dm_data(i_dm_data),
    .o_dm_data(o_dm_data),
    .o_err(o_err),
    .o_halt(o_halt),
    .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] we;
    logic [63:0] data;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb_q[$];
  logic [7:0]  tx_q[$];
  sb_t         ent;
  logic [7:0]  tx_exp;
  int          n_chk = 0;
  int          n_fail = 0;
  int          tb_cyc = 0;
  logic [63:0] last_rd = '0;
  logic [63:0] c1, c2;

  always @(posedge i_clk) tb_cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // every access checks rdata (held value on writes) and err one cycle later
  always @(negedge i_clk) begin
    while (sb_q.size() > 0 && sb_q[0].due == tb_cyc) begin
      ent = sb_q.pop_front();
      check("rdata", o_dm_data, ent.data);
      check("err", 64'(o_err), 64'(ent.err));
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst && o_tx_valid && i_tx_ready) begin
      if (tx_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_extra: got %h expected none", o_tx_data);
      end else begin
        tx_exp = tx_q.pop_front();
        check("tx_data", 64'(o_tx_data), 64'(tx_exp));
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] w,
                       input logic [63:0] d, input logic chk,
                       input logic [63:0] exp, input logic e);
    i_dm_addr = a;
    i_dm_we   = w;
    i_dm_data = d;
    i_dm_cs   = 1'b1;
    if (chk) begin
      if (w == '0) last_rd = exp;
      sb_q.push_back('{due: tb_cyc + 1, data: last_rd, err: e});
    end
    @(posedge i_clk);
    #1;
    i_dm_cs = 1'b0;
    i_dm_we = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic tx_push(input logic [7:0] b, input logic kept);
    issue(MB + 64'd2, 64'hFF, 64'(b), 1'b1, 64'd0, 1'b0);
    if (kept) tx_q.push_back(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{64'd5, '1, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0});
    vecs.push_back('{64'd5, 64'd0, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0});
    vecs.push_back('{64'd5, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{64'd5, 64'd0, 64'd0, 64'hDEAD_BEEF_0000_0000, 1'b0});
    vecs.push_back('{64'd7, '1, 64'h77, 64'd0, 1'b0});
    vecs.push_back('{64'd0, '1, 64'h1111, 64'd0, 1'b0});
    vecs.push_back('{64'd1023, '1, 64'hAAAA_5555_AAAA_5555, 64'd0, 1'b0});
    vecs.push_back('{64'd0, 64'd0, 64'd0, 64'h1111, 1'b0});
    vecs.push_back('{64'd1023, 64'd0, 64'd0, 64'hAAAA_5555_AAAA_5555, 1'b0});
    vecs.push_back('{64'd1031, 64'd0, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{64'd1031, '1, 64'hBAD, 64'd0, 1'b1});
    vecs.push_back('{64'd7, 64'd0, 64'd0, 64'h77, 1'b0});
    vecs.push_back('{64'd7, 64'hFF00, 64'h1234, 64'd0, 1'b0});
    vecs.push_back('{64'd7, 64'd0, 64'd0, 64'h1277, 1'b0});
    vecs.push_back('{MB + 64'd2, 64'd0, 64'd0, 64'd0, 1'b0});
    vecs.push_back('{MB + 64'd3, 64'd0, 64'd0, 64'h01, 1'b0});
    vecs.push_back('{MB + 64'd3, '1, 64'hFF, 64'd0, 1'b0});
    vecs.push_back('{MB + 64'd3, 64'd0, 64'd0, 64'h01, 1'b0});
    vecs.push_back('{MB + 64'd4, 64'd0, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{MB - 64'd1, 64'd0, 64'd0, 64'd0, 1'b1});
    vecs.push_back('{MB + 64'd1, 64'hFF, 64'hF0, 64'd0, 1'b0});
    vecs.push_back('{MB + 64'd1, 64'd0, 64'd0, 64'hF0, 1'b0});

    #12;
    check("rst_rdata", o_dm_data, 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_halt", 64'(o_halt), 64'd0);
    check("rst_tx_valid", 64'(o_tx_valid), 64'd0);
    check("rst_tx_data", 64'(o_tx_data), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      issue(vecs[i].addr, vecs[i].we, vecs[i].data, 1'b1,
            vecs[i].exp, vecs[i].err);
    check("halt_low", 64'(o_halt), 64'd0);

    issue(MB, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    c1 = o_dm_data;
    idle(9);
    issue(MB, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    c2 = o_dm_data;
    check("cycle_delta", c2 - c1, 64'd10);

    force dut.cycle_q = '1;
    issue(MB, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    check("cycle_at_max", o_dm_data, '1);
    check("cycle_wrap", dut.cycle_nxt, 64'd0);
    release dut.cycle_q;
    issue(64'd5, 64'd0, 64'd0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0);

    i_tx_ready = 1'b0;
    check("tx_empty_before", 64'(o_tx_valid), 64'd0);
    tx_push(8'h41, 1'b1);
    check("tx_valid_next", 64'(o_tx_valid), 64'd1);
    check("tx_head", 64'(o_tx_data), 64'h41);
    tx_push(8'h42, 1'b1);
    tx_push(8'h43, 1'b1);
    tx_push(8'h44, 1'b1);
    tx_push(8'h45, 1'b0);
    issue(MB + 64'd3, 64'd0, 64'd0, 1'b1, 64'h32, 1'b0);
    i_tx_ready = 1'b1;
    idle(8);
    check("tx_drained", 64'(tx_q.size()), 64'd0);
    check("tx_valid_drop", 64'(o_tx_valid), 64'd0);
    issue(MB + 64'd3, 64'd0, 64'd0, 1'b1, 64'h21, 1'b0);

    i_tx_ready = 1'b0;
    tx_push(8'h47, 1'b1);
    tx_push(8'h48, 1'b1);
    tx_push(8'h49, 1'b1);
    tx_push(8'h4A, 1'b1);
    i_tx_ready = 1'b1;
    tx_push(8'h4B, 1'b1);
    i_tx_ready = 1'b0;
    issue(MB + 64'd3, 64'd0, 64'd0, 1'b1, 64'h32, 1'b0);
    i_tx_ready = 1'b1;
    idle(8);
    check("tx_drained2", 64'(tx_q.size()), 64'd0);
    i_tx_ready = 1'b0;

    issue(MB + 64'd1, '1, 64'd1, 1'b1, 64'd0, 1'b0);
    check("halt_set", 64'(o_halt), 64'd1);
    issue(MB + 64'd1, '1, 64'd0, 1'b1, 64'd0, 1'b0);
    check("halt_sticky", 64'(o_halt), 64'd1);
    issue(64'd5, 64'd0, 64'd0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b0);
    idle(1);

    i_dm_addr = 64'd5;
    i_dm_we   = '0;
    i_dm_cs   = 1'b1;
    #3;
    i_rst = 1'b1;
    #1;
    check("async_rdata", o_dm_data, 64'd0);
    check("async_halt", 64'(o_halt), 64'd0);
    @(posedge i_clk);
    #1;
    i_dm_cs = 1'b0;
    i_rst   = 1'b0;
    last_rd = '0;
    check("inflight_drop", o_dm_data, 64'd0);
    issue(MB + 64'd3, 64'd0, 64'd0, 1'b1, 64'h01, 1'b0);
    issue(MB + 64'd1, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0);
    idle(2);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
